// File: rtl/star_box_painter.sv
// Draws the one-pixel outline of a bounding box into the 60x60 image RAM.
// Writes go top row, bottom row, left column, right column; each perimeter pixel is written exactly once.
module star_box_painter #(
  parameter int xSz          = 6,
  parameter int ySz          = 6,
  parameter int addrSz       = 12,
  parameter int colSz        = 3,
  parameter int x_resolution = 60,
  parameter int y_resolution = 60
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [xSz-1:0]    xLeft,
  input  logic [xSz-1:0]    xRight,
  input  logic [ySz-1:0]    yTop,
  input  logic [ySz-1:0]    yBottom,
  input  logic [colSz-1:0]  colour,
  output logic [addrSz-1:0] address,
  output logic [colSz-1:0]  data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, TOP, BOTTOM, LEFT, RIGHT, DONE} state_t;

  localparam logic [xSz-1:0] X_LIM = xSz'(x_resolution);
  localparam logic [ySz-1:0] Y_LIM = ySz'(y_resolution);

  state_t             state, state_n;
  logic [xSz-1:0]     x, x_n, xl, xr;
  logic [ySz-1:0]     y, y_n, yt, yb;
  logic [ySz-1:0]     span, yb_m1;
  logic [colSz-1:0]   col;
  logic               bad, invalid, accept;
  logic [addrSz-1:0]  yw;

  assign accept  = (state == IDLE) && start;
  assign invalid = (xLeft > xRight) || (yTop > yBottom) ||
                   (xRight >= X_LIM) || (yBottom >= Y_LIM);
  assign span    = yb - yt;
  assign yb_m1   = yb - 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      xl    <= '0;
      xr    <= '0;
      yt    <= '0;
      yb    <= '0;
      col   <= '0;
      bad   <= 1'b0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      if (accept) begin
        xl  <= xLeft;
        xr  <= xRight;
        yt  <= yTop;
        yb  <= yBottom;
        col <= colour;
        bad <= invalid;
      end
    end
  end

  // Empty edges (H==1, H<=2, W==1) are skipped inside the same transition.
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    case (state)
      IDLE: if (start) begin
        if (invalid) state_n = DONE;
        else begin
          state_n = TOP;
          x_n     = xLeft;
          y_n     = yTop;
        end
      end
      TOP: begin
        if (x == xr) begin
          if (yt == yb) state_n = DONE;
          else begin
            state_n = BOTTOM;
            x_n     = xl;
            y_n     = yb;
          end
        end else x_n = x + 1'b1;
      end
      BOTTOM: begin
        if (x == xr) begin
          if (span < ySz'(2)) state_n = DONE;
          else begin
            state_n = LEFT;
            x_n     = xl;
            y_n     = yt + 1'b1;
          end
        end else x_n = x + 1'b1;
      end
      LEFT: begin
        if (y == yb_m1) begin
          if (xl == xr) state_n = DONE;
          else begin
            state_n = RIGHT;
            x_n     = xr;
            y_n     = yt + 1'b1;
          end
        end else y_n = y + 1'b1;
      end
      RIGHT: begin
        if (y == yb_m1) state_n = DONE;
        else y_n = y + 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset drops wren without waiting for a clock.
  assign wren    = (state == TOP) || (state == BOTTOM) || (state == LEFT) || (state == RIGHT);
  assign busy    = wren;
  assign done    = (state == DONE);
  assign err     = done && bad;
  assign data    = col;
  assign yw      = addrSz'(y);
  assign address = (yw << 5) + (yw << 4) + (yw << 3) + (yw << 2) + addrSz'(x);

endmodule

// File: tb/tb_star_box_painter.sv
// Scoreboard bench for star_box_painter: the driver queues expected writes/done with their cycle,
// and the monitor pops and compares every wren/done cycle it observes.
module tb_star_box_painter;

  logic        clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [5:0]  xLeft = '0, xRight = '0, yTop = '0, yBottom = '0;
  logic [2:0]  colour = '0;
  logic [11:0] address;
  logic [2:0]  data;
  logic        wren, busy, done, err;

  star_box_painter dut (
    .clk(clk), .resetn(resetn), .start(start),
    .xLeft(xLeft), .xRight(xRight), .yTop(yTop), .yBottom(yBottom), .colour(colour),
    .address(address), .data(data), .wren(wren), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_done; int addr; int dat; bit err; int cyc;} exp_t;
  exp_t q[$];
  int cyc = 0, tests = 0, fails = 0;
  int wr_cnt = 0, last_addr = 0, max_addr = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string n, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (resetn && (wren || done)) begin
      if (wren) begin
        wr_cnt++;
        last_addr = int'(address);
        if (int'(address) > max_addr) max_addr = int'(address);
      end
      chk("wren_done_exclusive", int'(wren && done), 0);
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: wren=%0d done=%0d addr=%0d", wren, done, address);
      end else begin
        e = q.pop_front();
        chk("kind_done", int'(done), int'(e.is_done));
        chk("cycle", cyc, e.cyc);
        if (e.is_done) begin
          chk("err", int'(err), int'(e.err));
          chk("busy_in_done", int'(busy), 0);
        end else begin
          chk("address", int'(address), e.addr);
          chk("data", int'(data), e.dat);
          chk("busy_in_draw", int'(busy), 1);
        end
      end
    end
  end

  task automatic push_wr(int a, int d, int c);
    exp_t e;
    e.is_done = 1'b0; e.addr = a; e.dat = d; e.err = 1'b0; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic push_done(bit er, int c);
    exp_t e;
    e.is_done = 1'b1; e.addr = 0; e.dat = 0; e.err = er; e.cyc = c;
    q.push_back(e);
  endtask

  // Reference enumeration of the outline in drawing order, address = y*60 + x.
  task automatic model_box(int xl, int xr, int yt, int yb, int col, int acc);
    int n = 0;
    for (int x = xl; x <= xr; x++) begin push_wr(yt*60 + x, col, acc + n); n++; end
    if (yb != yt)
      for (int x = xl; x <= xr; x++) begin push_wr(yb*60 + x, col, acc + n); n++; end
    for (int y = yt + 1; y < yb; y++) begin push_wr(y*60 + xl, col, acc + n); n++; end
    if (xr != xl)
      for (int y = yt + 1; y < yb; y++) begin push_wr(y*60 + xr, col, acc + n); n++; end
    push_done(1'b0, acc + n);
  endtask

  task automatic push_case1(int acc);
    int exp_a[8] = '{1210, 1211, 1212, 1330, 1331, 1332, 1270, 1272};
    for (int i = 0; i < 8; i++) push_wr(exp_a[i], 5, acc + i);
    push_done(1'b0, acc + 8);
  endtask

  // Presents a request at a negedge; acc is the cycle index of the accepting posedge.
  task automatic kick(int xl, int xr, int yt, int yb, int col, output int acc);
    @(negedge clk);
    xLeft = 6'(xl); xRight = 6'(xr); yTop = 6'(yt); yBottom = 6'(yb); colour = 3'(col);
    start = 1'b1;
    acc = cyc + 1;
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
    xLeft = 6'd40; xRight = 6'd2; yTop = 6'd33; yBottom = 6'd1; colour = 3'd6;
  endtask

  task automatic drain(string n);
    int k = 0;
    while (q.size() != 0 && k < 400) begin @(negedge clk); #1; k++; end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: %0d expected items left", n, q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int acc, w0;
    #1;
    chk("rst_wren", int'(wren), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_address", int'(address), 0);
    chk("rst_data", int'(data), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // 1: 3x3 box
    kick(10, 12, 20, 22, 5, acc); push_case1(acc); w0 = wr_cnt;
    release_start(); drain("t1");
    chk("t1_write_count", wr_cnt - w0, 8);

    // 2: single pixel
    kick(5, 5, 5, 5, 7, acc); push_wr(305, 7, acc); push_done(1'b0, acc + 1); w0 = wr_cnt;
    release_start(); drain("t2");
    chk("t2_write_count", wr_cnt - w0, 1);

    // 3: full frame
    max_addr = 0;
    kick(0, 59, 0, 59, 3, acc); model_box(0, 59, 0, 59, 3, acc); w0 = wr_cnt;
    release_start(); drain("t3");
    chk("t3_write_count", wr_cnt - w0, 236);
    chk("t3_last_addr", last_addr, 3539);
    chk("t3_max_le_3599", int'(max_addr <= 3599), 1);

    // Two-row box and one-column box exercise the skip paths
    kick(10, 12, 1, 2, 4, acc); model_box(10, 12, 1, 2, 4, acc); w0 = wr_cnt;
    release_start(); drain("h2");
    chk("h2_write_count", wr_cnt - w0, 6);
    kick(3, 3, 0, 3, 1, acc); model_box(3, 3, 0, 3, 1, acc); w0 = wr_cnt;
    release_start(); drain("w1");
    chk("w1_write_count", wr_cnt - w0, 4);

    // 4: rejected boxes
    kick(12, 10, 0, 0, 1, acc); push_done(1'b1, acc); w0 = wr_cnt;
    release_start(); drain("t4a");
    chk("t4a_write_count", wr_cnt - w0, 0);
    kick(0, 0, 0, 60, 1, acc); push_done(1'b1, acc); w0 = wr_cnt;
    release_start(); drain("t4b");
    chk("t4b_write_count", wr_cnt - w0, 0);

    // 5: reset after the 3rd write
    kick(10, 12, 20, 22, 5, acc); push_case1(acc); w0 = wr_cnt;
    release_start();
    for (int k = 0; k < 50; k++) begin
      if (wr_cnt >= w0 + 3) break;
      @(negedge clk); #1;
    end
    chk("t5_writes_before_reset", wr_cnt - w0, 3);
    #1 resetn = 1'b0;
    #1;
    chk("t5_wren_async", int'(wren), 0);
    chk("t5_busy_async", int'(busy), 0);
    q.delete();
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    repeat (3) @(negedge clk);
    kick(10, 12, 20, 22, 5, acc); push_case1(acc); w0 = wr_cnt;
    release_start(); drain("t5");
    chk("t5_redraw_count", wr_cnt - w0, 8);

    // 6: start held with a different box presented after acceptance
    kick(10, 12, 20, 22, 5, acc); push_case1(acc); w0 = wr_cnt;
    @(negedge clk);
    xLeft = 6'd0; xRight = 6'd59; yTop = 6'd0; yBottom = 6'd59; colour = 3'd2;
    repeat (9) @(negedge clk);
    start = 1'b0;
    drain("t6");
    chk("t6_write_count", wr_cnt - w0, 8);
    kick(5, 5, 5, 5, 7, acc); push_wr(305, 7, acc); push_done(1'b0, acc + 1); w0 = wr_cnt;
    release_start(); drain("t6b");
    chk("t6b_write_count", wr_cnt - w0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
